// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_if
// Description : Controller-side bus bundle for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if;
    logic        IorD;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] wdata;
    logic        IRWrite;
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        mem_busy;
    logic        mem_done;
    logic        err;

    modport master (
        output IorD, pc, alu_out, MemRead, MemWrite, wdata, IRWrite,
        input  instr, mdr, mem_busy, mem_done, err
    );

    modport slave (
        input  IorD, pc, alu_out, MemRead, MemWrite, wdata, IRWrite,
        output instr, mdr, mem_busy, mem_done, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Multi-cycle word RAM access unit with MDR, IR and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  wire         clk,
    input  wire         rst,
    mem_access_if.slave bus
);

    localparam int         C_DEPTH     = 1 << DEPTH_LOG2;
    localparam int         C_AW        = DEPTH_LOG2 + 2;
    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [C_AW-1:0] addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            is_write_q, is_write_d;
    logic [31:0]     mdr_q, mdr_d;
    logic [31:0]     instr_q;
    logic            err_q, err_d;

    logic [31:0]           ram_q [0:C_DEPTH-1] = '{default: 32'h0};
    logic [31:0]           w_addr_sel;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_aligned;
    logic                  w_access;
    logic                  w_ram_we;
    logic                  w_unused_addr_hi;

    // Bits above the RAM index are deliberately discarded (address wrap).
    assign w_addr_sel       = bus.IorD ? bus.pc : bus.alu_out;
    assign w_unused_addr_hi = ^w_addr_sel[31:C_AW];
    assign w_idx            = addr_q[C_AW-1:2];
    assign w_aligned        = (addr_q[1:0] == 2'b00);
    assign w_ram_we         = w_access && is_write_q && w_aligned;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        mdr_d      = mdr_q;
        err_d      = err_q;
        w_access   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.MemRead || bus.MemWrite) begin
                    state_d    = S_WAIT;
                    cnt_d      = C_WAIT_LOAD;
                    addr_d     = w_addr_sel[C_AW-1:0];
                    wdata_d    = bus.wdata;
                    is_write_d = bus.MemWrite;
                    if ((bus.MemRead && bus.MemWrite) || (w_addr_sel[1:0] != 2'b00)) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_DONE;
                    w_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_HOLD;
            end
            default: begin
                // Wait for the level-held strobes to drop before re-arming.
                if (!bus.MemRead && !bus.MemWrite) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        if (w_access && !is_write_q && w_aligned) begin
            mdr_d = ram_q[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            is_write_q <= 1'b0;
            mdr_q      <= 32'h0;
            instr_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            mdr_q      <= mdr_d;
            err_q      <= err_d;
            if (bus.IRWrite) begin
                instr_q <= mdr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_ram_we) begin
            ram_q[w_idx] <= wdata_q;
        end
    end

    assign bus.instr    = instr_q;
    assign bus.mdr      = mdr_q;
    assign bus.mem_busy = (state_q == S_WAIT);
    assign bus.mem_done = (state_q == S_DONE);
    assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench: timestamp-based reference model plus
//               directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mem_access_if bus ();

    mem_access_unit #(.WAIT_CYCLES(W), .DEPTH_LOG2(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an access accepted at edge A finishes at edge A+W.
    logic [31:0] m_ram [0:255];
    logic [31:0] m_mdr, m_instr, m_addr, m_data, m_old_mdr, m_a;
    logic        m_err, m_write, m_pending, m_holding;
    bit          m_valid = 0;
    int          edge_n = 0;
    int          m_acc_edge = -100;
    int          m_done_edge = -100;

    initial for (int i = 0; i < 256; i++) m_ram[i] = 32'h0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_valid   = 1;
            m_pending = 0;
            m_holding = 0;
            m_mdr     = 32'h0;
            m_instr   = 32'h0;
            m_err     = 0;
        end else if (m_valid) begin
            m_old_mdr = m_mdr;
            if (!m_pending && !m_holding) begin
                if (bus.MemRead || bus.MemWrite) begin
                    m_a        = bus.IorD ? bus.pc : bus.alu_out;
                    m_pending  = 1;
                    m_acc_edge = edge_n;
                    m_addr     = m_a;
                    m_data     = bus.wdata;
                    m_write    = bus.MemWrite;
                    if (m_a[1:0] != 2'b00 || (bus.MemRead && bus.MemWrite)) m_err = 1;
                end
            end else if (m_pending) begin
                if (edge_n == m_acc_edge + W) begin
                    m_pending   = 0;
                    m_holding   = 1;
                    m_done_edge = edge_n;
                    if (m_addr[1:0] == 2'b00) begin
                        if (m_write) m_ram[m_addr[9:2]] = m_data;
                        else         m_mdr = m_ram[m_addr[9:2]];
                    end
                end
            end else if (edge_n >= m_done_edge + 2 && !bus.MemRead && !bus.MemWrite) begin
                m_holding = 0;
            end
            if (bus.IRWrite) m_instr = m_old_mdr;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("mem_busy", {31'b0, bus.mem_busy}, {31'b0, m_pending});
            chk("mem_done", {31'b0, bus.mem_done}, {31'b0, (m_holding && edge_n == m_done_edge)});
            chk("mdr", bus.mdr, m_mdr);
            chk("instr", bus.instr, m_instr);
            chk("err", {31'b0, bus.err}, {31'b0, m_err});
        end
    end

    // One access: drive, scramble inputs during WAIT, measure latency, release.
    task automatic access(input bit rd, input bit wr, input bit iord,
                          input logic [31:0] addr, input logic [31:0] data,
                          input string name);
        int lat;
        bus.IorD     = iord;
        bus.pc       = iord ? addr : 32'h0000_00F8;
        bus.alu_out  = iord ? 32'h0000_00F4 : addr;
        bus.wdata    = data;
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) begin
                bus.IorD    = ~iord;
                bus.pc      = 32'h0000_00EC;
                bus.alu_out = 32'h0000_00E8;
                bus.wdata   = ~data;
            end
            @(negedge clk);
            if (bus.mem_done) break;
        end
        chk({name, "_latency"}, lat, W + 1);
        @(posedge clk); #1;
        bus.MemRead  = 0;
        bus.MemWrite = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    int pulses;

    initial begin
        bus.IorD = 0; bus.pc = 0; bus.alu_out = 0; bus.MemRead = 0;
        bus.MemWrite = 0; bus.wdata = 0; bus.IRWrite = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_mdr", bus.mdr, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_err", {31'b0, bus.err}, 32'h0);
        chk("rst_busy", {31'b0, bus.mem_busy}, 32'h0);
        chk("rst_done", {31'b0, bus.mem_done}, 32'h0);
        @(posedge clk); #1;

        // Basic write then read through the other address source
        access(0, 1, 0, 32'h10, 32'hDEADBEEF, "wr10");
        access(1, 0, 1, 32'h10, 32'h0, "rd10");
        chk("basic_mdr", bus.mdr, 32'hDEADBEEF);
        chk("basic_err", {31'b0, bus.err}, 32'h0);

        // Level-held read strobe gives exactly one access
        bus.IorD = 0; bus.alu_out = 32'h10; bus.MemRead = 1;
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_done) pulses++;
        end
        chk("held_pulses", pulses, 1);
        chk("held_not_busy", {31'b0, bus.mem_busy}, 32'h0);
        @(posedge clk); #1 bus.MemRead = 0;
        @(posedge clk); #1;

        // Misaligned read leaves mdr alone and sets sticky err
        access(0, 1, 0, 32'h40, 32'h12345678, "wr40");
        access(1, 0, 0, 32'h40, 32'h0, "rd40");
        chk("pre_mis_mdr", bus.mdr, 32'h12345678);
        access(1, 0, 0, 32'h13, 32'h0, "rd13");
        chk("mis_mdr", bus.mdr, 32'h12345678);
        chk("mis_err", {31'b0, bus.err}, 32'h1);
        access(1, 0, 0, 32'h10, 32'h0, "rd10b");
        chk("err_sticky", {31'b0, bus.err}, 32'h1);
        chk("after_mis_mdr", bus.mdr, 32'hDEADBEEF);

        rst = 1; @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("err_cleared", {31'b0, bus.err}, 32'h0);
        @(posedge clk); #1;

        // Address wrap: 0x400 aliases word 0
        access(0, 1, 0, 32'h400, 32'hA5A5A5A5, "wr400");
        access(1, 0, 1, 32'h000, 32'h0, "rd000");
        chk("wrap_mdr", bus.mdr, 32'hA5A5A5A5);

        // Reset in first WAIT cycle aborts the write
        bus.IorD = 0; bus.alu_out = 32'h20; bus.wdata = 32'h11111111; bus.MemWrite = 1;
        @(posedge clk); #1;
        rst = 1; bus.MemWrite = 0;
        @(posedge clk); #1 rst = 0;
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_done) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        @(posedge clk); #1;
        access(1, 0, 0, 32'h20, 32'h0, "rd20");
        chk("abort_mdr", bus.mdr, 32'h0);

        // Both strobes: treated as write and flagged
        access(1, 1, 0, 32'h30, 32'h55AA00FF, "both30");
        chk("both_err", {31'b0, bus.err}, 32'h1);
        access(1, 0, 0, 32'h30, 32'h0, "rd30");
        chk("both_mdr", bus.mdr, 32'h55AA00FF);

        // Instruction load from mdr
        access(0, 1, 0, 32'h0, 32'h8C010004, "wr0");
        access(1, 0, 1, 32'h0, 32'h0, "rd0");
        bus.IRWrite = 1;
        @(posedge clk); #1 bus.IRWrite = 0;
        @(negedge clk);
        chk("instr_load", bus.instr, 32'h8C010004);
        @(posedge clk); #1;

        // IRWrite held across a read edge captures the previous mdr
        access(0, 1, 0, 32'h4, 32'h00000777, "wr4");
        bus.IRWrite = 1;
        access(1, 0, 0, 32'h4, 32'h0, "rd4");
        bus.IRWrite = 0;
        chk("instr_new", bus.instr, 32'h00000777);
        @(posedge clk); #1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
